// File: rtl/note_player.sv
// Note player: holds a note from song_reader for `duration` units of BEAT_DIV beat ticks,
// then returns a one-cycle note_done pulse. Supports pause and preemption.
module note_player #(
    parameter int unsigned NOTE_W   = 6,
    parameter int unsigned DUR_W    = 6,
    parameter int unsigned BEAT_DIV = 1,
    parameter int unsigned DIV_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_enable,
    input  logic              beat,
    input  logic              new_note,
    input  logic [NOTE_W-1:0] note,
    input  logic [DUR_W-1:0]  duration,
    output logic              note_done,
    output logic [NOTE_W-1:0] cur_note,
    output logic              note_active,
    output logic [DUR_W-1:0]  remaining
);

    typedef enum logic [1:0] {StIdle, StPlaying, StDone} state_e;

    localparam logic [DIV_W-1:0] LastTick = DIV_W'(BEAT_DIV - 1);

    state_e             state_q, state_d;
    logic [NOTE_W-1:0]  cur_note_q, cur_note_d;
    logic [DUR_W-1:0]   remaining_q, remaining_d;
    logic [DIV_W-1:0]   presc_q, presc_d;

    always_comb begin
        state_d     = state_q;
        cur_note_d  = cur_note_q;
        remaining_d = remaining_q;
        presc_d     = presc_q;

        // A new note always wins: loads from any state, beats in the same cycle are ignored.
        if (new_note) begin
            cur_note_d  = note;
            remaining_d = duration;
            presc_d     = '0;
            state_d     = (duration != '0) ? StPlaying : StDone;
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StDone: state_d = StIdle;
                StPlaying: begin
                    if (beat && play_enable) begin
                        if (presc_q == LastTick) begin
                            presc_d = '0;
                            if (remaining_q <= DUR_W'(1)) begin
                                remaining_d = '0;
                                state_d     = StDone;
                            end else begin
                                remaining_d = remaining_q - DUR_W'(1);
                            end
                        end else begin
                            presc_d = presc_q + DIV_W'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cur_note_q  <= '0;
            remaining_q <= '0;
            presc_q     <= '0;
        end else begin
            state_q     <= state_d;
            cur_note_q  <= cur_note_d;
            remaining_q <= remaining_d;
            presc_q     <= presc_d;
        end
    end

    always_comb begin
        note_done   = (state_q == StDone);
        cur_note    = cur_note_q;
        remaining   = remaining_q;
        note_active = (state_q == StPlaying) && play_enable && (cur_note_q != '0);
    end

endmodule

// File: doc/note_player.md
Name: note_player

Overview:
- Consumer end of the song_reader note handshake.
- Accepts a new_note pulse with note/duration from song_reader and holds the note for `duration` units.
- Each unit is BEAT_DIV beat ticks from the beat generator. At expiry it returns a one-cycle note_done pulse to song_reader.
- Drives cur_note/note_active to the downstream frequency/sine stage and supports pause via play_enable.

Parameters:
- NOTE_W, 6, width of note code.
- DUR_W, 6, width of duration (units).
- BEAT_DIV, 1, beat ticks per duration unit (>=1).
- DIV_W, 8, width of the internal tick prescaler; must satisfy BEAT_DIV <= 2^DIV_W.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low; clears all state.
- play_enable  input  1  1 = run, 0 = pause.
- beat  input  1  single-cycle tick from the beat generator.
- new_note  input  1  single-cycle pulse; note/duration valid in the same cycle.
- note  input  NOTE_W  note code; 0 = rest.
- duration  input  DUR_W  length in units; 0 = zero-length.
- note_done  output  1  single-cycle pulse: current note finished.
- cur_note  output  NOTE_W  latched note code.
- note_active  output  1  high while sounding: PLAYING, play_enable=1, cur_note!=0.
- remaining  output  DUR_W  units left in the current note.

Behaviour:
- Reset (reset=0, async): state=IDLE. note_done=0, cur_note=0, note_active=0, remaining=0, prescaler=0.
- States: IDLE, PLAYING, DONE.
- IDLE:
  - new_note=1 with duration!=0: latch cur_note=note, remaining=duration, prescaler=0 -> PLAYING.
  - new_note=1 with duration=0: latch cur_note -> DONE (no beats consumed).
- PLAYING:
  - A beat with play_enable=1 increments the prescaler.
  - When prescaler reaches BEAT_DIV-1 on a beat: prescaler<=0, remaining<=remaining-1.
  - If remaining was 1 on that unit edge: -> DONE, remaining=0.
- DONE: note_done=1 for exactly this one cycle, then -> IDLE. cur_note holds until the next new_note.
- note_done is registered and high only while in DONE. Never asserted twice per accepted note.
- Latency:
  - new_note sampled at edge k; cur_note and remaining are valid after edge k.
  - Beat ticks counted from edge k+1 onward; a beat coincident with new_note is not counted.
  - Last unit decrement at edge m gives note_done high during cycle m+1.
- Pause:
  - play_enable=0 ignores beats, freezes prescaler/remaining and forces note_active=0.
  - State is retained; resume continues the count exactly.
  - new_note is still accepted while paused.
- Preemption: new_note in PLAYING reloads cur_note/remaining, clears the prescaler and stays in PLAYING. No note_done for the aborted note.
- Simultaneous final unit and new_note in PLAYING: new_note wins (reload, no note_done).
- new_note while in DONE: note_done still pulses this cycle. The new note is loaded per the IDLE rules on the same edge, so the next state is PLAYING or DONE.
- Rest (note=0): timed identically; note_active stays 0 throughout.
- Widths: remaining decrement never underflows; it saturates at 0 in IDLE/DONE. The prescaler wraps only via the BEAT_DIV compare.
- Reset asserted mid-note: immediate return to the reset values above. No note_done is produced.

Test Plan:
- Reset: assert reset=0 mid-PLAYING -> all outputs 0 asynchronously. After release and no new_note, note_done stays 0 for 50 cycles.
- Basic note, BEAT_DIV=1, play_enable=1, beat every 4 cycles: new_note with note=12, duration=3 -> cur_note=12, remaining 3,2,1,0 on successive beats. note_done high exactly one cycle after the third beat edge; note_active=1 until DONE.
- BEAT_DIV=4, duration=2: requires exactly 8 beats -> note_done after the 8th beat. remaining decrements on beats 4 and 8 only.
- Pause: duration=4; drop play_enable after 2 units for 20 beats, then restore -> remaining frozen at 2 and note_active=0 during the pause. note_done after 2 more beats.
- Zero-length and rest:
  - duration=0, note=5 -> note_done one cycle after new_note, no beats consumed.
  - note=0, duration=2 -> note_active never 1; note_done after 2 beats.
- Preemption/collision:
  - new_note (note=7, duration=5) two beats into a duration=3 note -> no note_done; remaining=5.
  - new_note coincident with the final beat -> new note loaded, no note_done.
  - Full song_reader loop of 4 notes -> 4 note_done pulses total.
